// File: rtl/uart_tx_engine_if.sv
// FIFO-side handshake of the UART transmit engine: empty flag, read data and pop strobe.
// The engine takes the master modport, the tx FIFO the slave modport.
interface uart_tx_engine_if #(
    parameter int DATA_MAX = 9
);
    logic                p_FiFoEmpty_i;
    logic [DATA_MAX-1:0] FiFoData_i;
    logic                p_FiFoRead_o;

    modport master (input p_FiFoEmpty_i, input FiFoData_i, output p_FiFoRead_o);
    modport slave  (output p_FiFoEmpty_i, output FiFoData_i, input p_FiFoRead_o);
endinterface

// File: rtl/uart_tx_engine.sv
// Parametrised UART transmitter: runtime data length, parity, stop length and inter-frame gap.
// Define UART_TX_TMR_EN to triplicate state, counters and shift register behind 2-of-3 voters.
module uart_tx_engine #(
    parameter int DATA_MAX = 9,
    parameter int GAP_BITS = 0
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_engine_if.master  fifo,
    input  logic              p_HalfBaudSig_i,
    input  logic              Enable_i,
    input  logic [3:0]        DataBits_i,
    input  logic [2:0]        ParityMode_i,
    input  logic [1:0]        StopBits_i,
    output logic              Tx_o,
    output logic [5:0]        State_o,
    output logic [3:0]        BitCounter_o,
    output logic              Busy_o,
    output logic              p_ByteDone_o
);

    typedef enum logic [5:0] {
        INTERVAL  = 6'b00_0001,
        LOAD      = 6'b00_0010,
        STARTBIT  = 6'b00_0100,
        DATABITS  = 6'b00_1000,
        PARITYBIT = 6'b01_0000,
        STOPBIT   = 6'b10_0000
    } state_t;

    // Everything that is triplicated under TMR lives in one packed word so a single voter covers it.
    typedef struct packed {
        logic [5:0]          state;
        logic [1:0]          tick;
        logic [3:0]          bits;
        logic [4:0]          gap;
        logic [DATA_MAX-1:0] shift;
    } core_t;

    localparam logic [4:0] GAP_TICKS = 5'(2 * GAP_BITS);
    localparam logic [3:0] LEN_MAX   = 4'(DATA_MAX);
    localparam core_t      CORE_RST  = '{state: INTERVAL, tick: '0, bits: '0, gap: '0, shift: '0};

    core_t      cur, nxt;
    logic [3:0] len_q, len_d, len_in;
    logic [2:0] mode_q, mode_d;
    logic [1:0] stop_q, stop_d, stop_last;
    logic       par_q, par_d, par_en, par_bit;
    logic       tx_q, tx_d;
    logic       fifo_rd, done;

    always_comb begin
        // NOTE: every combinationally written signal gets a default first so no latch is inferred.
        len_in = DataBits_i;
        if (DataBits_i < 4'd5)
            len_in = 4'd5;
        else if (DataBits_i > LEN_MAX)
            len_in = LEN_MAX;
    end

    assign par_en = (mode_q >= 3'd1) && (mode_q <= 3'd4);

    always_comb begin
        unique case (stop_q)
            2'b00:   stop_last = 2'd1;
            2'b01:   stop_last = 2'd2;
            default: stop_last = 2'd3;
        endcase
    end

    always_comb begin
        nxt     = cur;
        len_d   = len_q;
        mode_d  = mode_q;
        stop_d  = stop_q;
        par_d   = par_q;
        fifo_rd = 1'b0;
        done    = 1'b0;
        case (cur.state)
            INTERVAL: begin
                nxt.tick = '0;
                nxt.bits = '0;
                if (p_HalfBaudSig_i && cur.gap < GAP_TICKS)
                    nxt.gap = cur.gap + 5'd1;
                if (p_HalfBaudSig_i && cur.gap >= GAP_TICKS && !fifo.p_FiFoEmpty_i && Enable_i) begin
                    fifo_rd   = 1'b1;
                    nxt.state = LOAD;
                end
            end
            LOAD: begin
                nxt.shift = fifo.FiFoData_i;
                nxt.tick  = '0;
                nxt.bits  = '0;
                len_d     = len_in;
                mode_d    = ParityMode_i;
                stop_d    = StopBits_i;
                par_d     = 1'b0;
                nxt.state = STARTBIT;
            end
            STARTBIT, PARITYBIT: begin
                if (p_HalfBaudSig_i) begin
                    nxt.tick = cur.tick + 2'd1;
                    if (cur.tick == 2'd1) begin
                        nxt.tick  = '0;
                        nxt.state = (cur.state == STARTBIT) ? DATABITS : STOPBIT;
                    end
                end
            end
            DATABITS: begin
                if (p_HalfBaudSig_i) begin
                    nxt.tick = cur.tick + 2'd1;
                    if (cur.tick == 2'd1) begin
                        nxt.tick  = '0;
                        nxt.shift = cur.shift >> 1;
                        nxt.bits  = cur.bits + 4'd1;
                        par_d     = par_q ^ cur.shift[0];
                        if (cur.bits + 4'd1 == len_q)
                            nxt.state = par_en ? PARITYBIT : STOPBIT;
                    end
                end
            end
            STOPBIT: begin
                if (p_HalfBaudSig_i) begin
                    nxt.tick = cur.tick + 2'd1;
                    if (cur.tick == stop_last) begin
                        done      = 1'b1;
                        nxt.tick  = '0;
                        nxt.bits  = '0;
                        nxt.gap   = '0;
                        nxt.state = INTERVAL;
                    end
                end
            end
            default: begin
                // Corrupted (non-one-hot) state: fall back to a clean idle line.
                nxt   = CORE_RST;
                par_d = 1'b0;
            end
        endcase

        unique case (mode_q)
            3'b001:  par_bit = ~par_d;
            3'b010:  par_bit = par_d;
            3'b011:  par_bit = 1'b1;
            default: par_bit = 1'b0;
        endcase

        // Line level is derived from the next state so the registered Tx_o lines up with State_o.
        case (nxt.state)
            STARTBIT:  tx_d = 1'b0;
            DATABITS:  tx_d = nxt.shift[0];
            PARITYBIT: tx_d = par_bit;
            default:   tx_d = 1'b1;
        endcase
    end

`ifdef UART_TX_TMR_EN
    core_t core_r [3];

    assign cur = (core_r[0] & core_r[1]) | (core_r[0] & core_r[2]) | (core_r[1] & core_r[2]);

    always_ff @(posedge clk or posedge rst) begin
        for (int i = 0; i < 3; i++) begin
            if (rst)
                core_r[i] <= CORE_RST;
            else
                core_r[i] <= nxt;
        end
    end
`else
    core_t core_r;

    assign cur = core_r;

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst)
            core_r <= CORE_RST;
        else
            core_r <= nxt;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q  <= '0;
            mode_q <= '0;
            stop_q <= '0;
            par_q  <= 1'b0;
            tx_q   <= 1'b1;
        end else begin
            len_q  <= len_d;
            mode_q <= mode_d;
            stop_q <= stop_d;
            par_q  <= par_d;
            tx_q   <= tx_d;
        end
    end

    assign Tx_o              = tx_q;
    assign State_o           = cur.state;
    assign BitCounter_o      = cur.bits;
    assign Busy_o            = (cur.state != INTERVAL);
    assign p_ByteDone_o      = done;
    assign fifo.p_FiFoRead_o = fifo_rd;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: directed frames, random frames, gap, enable and reset cases.
// Expected line levels come from a per-tick waveform built straight from the frame format.
module tb_uart_tx_engine;

    localparam int DATA_MAX = 9;
    localparam int GAP_BITS = 2;
    localparam int TICK_DIV = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       p_HalfBaudSig_i = 1'b0;
    logic       Enable_i = 1'b0;
    logic [3:0] DataBits_i = 4'd8;
    logic [2:0] ParityMode_i = 3'd0;
    logic [1:0] StopBits_i = 2'd0;
    logic       Tx_o;
    logic [5:0] State_o;
    logic [3:0] BitCounter_o;
    logic       Busy_o;
    logic       p_ByteDone_o;

    uart_tx_engine_if #(.DATA_MAX(DATA_MAX)) fifo ();

    uart_tx_engine #(.DATA_MAX(DATA_MAX), .GAP_BITS(GAP_BITS)) dut (
        .clk             (clk),
        .rst             (rst),
        .fifo            (fifo),
        .p_HalfBaudSig_i (p_HalfBaudSig_i),
        .Enable_i        (Enable_i),
        .DataBits_i      (DataBits_i),
        .ParityMode_i    (ParityMode_i),
        .StopBits_i      (StopBits_i),
        .Tx_o            (Tx_o),
        .State_o         (State_o),
        .BitCounter_o    (BitCounter_o),
        .Busy_o          (Busy_o),
        .p_ByteDone_o    (p_ByteDone_o)
    );

    int n_cmp = 0;
    int n_err = 0;
    int n_reads = 0;
    int n_done = 0;

    logic [DATA_MAX-1:0] fq [$];
    bit                  exp_lv [$];
    int                  exp_len;

    initial forever #5 clk = ~clk;

    // Half-bit tick: one clk pulse every TICK_DIV clks, changed just after the rising edge.
    initial begin
        int c = 0;
        forever begin
            @(posedge clk);
            #1;
            p_HalfBaudSig_i = (c == 0);
            c = (c + 1) % TICK_DIV;
        end
    end

    // FIFO model: pop on p_FiFoRead_o, data valid the clk after the pop.
    initial begin
        fifo.p_FiFoEmpty_i = 1'b1;
        fifo.FiFoData_i    = '0;
        forever begin
            @(negedge clk);
            if (fifo.p_FiFoRead_o) begin
                n_reads++;
                @(posedge clk);
                #1;
                if (fq.size() > 0)
                    fifo.FiFoData_i = fq.pop_front();
                fifo.p_FiFoEmpty_i = (fq.size() == 0);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (p_ByteDone_o)
            n_done++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no end of test, required completion");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int v);
        fq.push_back(DATA_MAX'(v));
        fifo.p_FiFoEmpty_i = 1'b0;
    endtask

    // Per-tick line levels of one frame: start, data LSB first, optional parity, stop.
    function automatic void build(input int data, input int dbits, input int pm, input int sb);
        int ones = 0;
        int nstop;
        bit p;
        exp_lv.delete();
        exp_len = (dbits < 5) ? 5 : ((dbits > DATA_MAX) ? DATA_MAX : dbits);
        exp_lv.push_back(1'b0);
        exp_lv.push_back(1'b0);
        for (int i = 0; i < exp_len; i++) begin
            bit b = bit'((data >> i) & 1);
            ones += int'(b);
            exp_lv.push_back(b);
            exp_lv.push_back(b);
        end
        if (pm >= 1 && pm <= 4) begin
            p = (pm == 1) ? (ones % 2 == 0) : (pm == 2) ? (ones % 2 == 1) : (pm == 3);
            exp_lv.push_back(p);
            exp_lv.push_back(p);
        end
        nstop = (sb == 0) ? 2 : (sb == 1) ? 3 : 4;
        for (int i = 0; i < nstop; i++)
            exp_lv.push_back(1'b1);
    endfunction

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4 * TICK_DIV; i++) begin
            @(negedge clk);
            if (p_HalfBaudSig_i) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    // Sends one frame already queued in the FIFO; exp_idle < 0 skips the idle-gap check.
    task automatic run_frame(input int data, input int dbits, input int pm, input int sb,
                             input bit drop_en, input int exp_idle);
        int idle = 0;
        bit got = 1'b0;
        bit ok;
        int done_before;
        int exp_bc;
        build(data, dbits, pm, sb);
        DataBits_i   = 4'(dbits);
        ParityMode_i = 3'(pm);
        StopBits_i   = 2'(sb);
        Enable_i     = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (fifo.p_FiFoRead_o) begin
                got = 1'b1;
                break;
            end
            if (p_HalfBaudSig_i) begin
                idle++;
                check("idle_tx", Tx_o, 1);
            end
        end
        check("read_seen", got, 1);
        if (!got)
            return;
        check("read_on_tick", p_HalfBaudSig_i, 1);
        if (exp_idle >= 0)
            check("gap_ticks", idle, exp_idle);
        done_before = n_done;
        for (int k = 0; k < exp_lv.size(); k++) begin
            wait_tick(ok);
            check("tick_seen", ok, 1);
            check("tx_level", Tx_o, exp_lv[k]);
            check("busy", Busy_o, 1);
            check("byte_done", p_ByteDone_o, (k == exp_lv.size() - 1));
            exp_bc = (k < 2) ? 0 : (((k - 2) / 2 < exp_len) ? (k - 2) / 2 : exp_len);
            check("bit_counter", BitCounter_o, exp_bc);
            if (k == 1) begin
                DataBits_i   = 4'($urandom);
                ParityMode_i = 3'($urandom);
                StopBits_i   = 2'($urandom);
                if (drop_en)
                    Enable_i = 1'b0;
            end
        end
        @(negedge clk);
        check("end_state", State_o, 6'b00_0001);
        check("end_tx", Tx_o, 1);
        check("end_bitcnt", BitCounter_o, 0);
        check("end_busy", Busy_o, 0);
        check("done_count", n_done, done_before + 1);
    endtask

    initial begin
        bit ok;
        bit got;
        int reads_before;
        int done_before;
        int r1, r2;

        repeat (3) @(negedge clk);
        check("rst_state", State_o, 6'b00_0001);
        check("rst_tx", Tx_o, 1);
        check("rst_bitcnt", BitCounter_o, 0);
        check("rst_busy", Busy_o, 0);
        check("rst_read", fifo.p_FiFoRead_o, 0);
        check("rst_done", p_ByteDone_o, 0);
        rst = 1'b0;

        // Directed frame formats, including data-length clamping at both ends.
        push(9'h055); run_frame(9'h055, 8, 0, 0, 1'b0, -1);
        push(9'h041); run_frame(9'h041, 7, 2, 2, 1'b0, -1);
        push(9'h01F); run_frame(9'h01F, 5, 1, 1, 1'b0, -1);
        push(9'h100); run_frame(9'h100, 9, 3, 0, 1'b0, -1);
        push(9'h01B); run_frame(9'h01B, 3, 0, 0, 1'b0, -1);
        push(9'h1A5); run_frame(9'h1A5, 12, 4, 3, 1'b0, -1);

        // Two queued bytes: minimum gap of 2*GAP_BITS idle ticks between frames.
        push(9'h0A5); push(9'h03C);
        run_frame(9'h0A5, 8, 0, 0, 1'b0, -1);
        run_frame(9'h03C, 8, 2, 0, 1'b0, 2 * GAP_BITS);

        // Enable dropped mid-frame: frame completes, queued byte waits.
        push(9'h0AA); push(9'h133);
        run_frame(9'h0AA, 8, 1, 0, 1'b1, -1);
        reads_before = n_reads;
        repeat (60) @(negedge clk);
        check("no_read_after_disable", n_reads, reads_before);
        check("disabled_tx", Tx_o, 1);
        run_frame(9'h133, 9, 2, 1, 1'b0, -1);

        // Enable low with a non-empty FIFO: no pop.
        Enable_i = 1'b0;
        push(9'h07E);
        reads_before = n_reads;
        repeat (60) @(negedge clk);
        check("no_read_disabled", n_reads, reads_before);
        run_frame(9'h07E, 7, 4, 0, 1'b0, -1);

        // Reset mid-DATABITS: immediate idle, partial frame discarded, next byte sent intact.
        push(9'h0F0); push(9'h155);
        DataBits_i = 4'd9; ParityMode_i = 3'd0; StopBits_i = 2'd0; Enable_i = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (fifo.p_FiFoRead_o) begin
                got = 1'b1;
                break;
            end
        end
        check("abort_read_seen", got, 1);
        repeat (6) wait_tick(ok);
        done_before = n_done;
        check("abort_mid_busy", Busy_o, 1);
        rst = 1'b1;
        #1;
        check("abort_tx", Tx_o, 1);
        check("abort_state", State_o, 6'b00_0001);
        check("abort_bitcnt", BitCounter_o, 0);
        check("abort_busy", Busy_o, 0);
        @(negedge clk);
        rst = 1'b0;
        reads_before = n_reads;
        run_frame(9'h155, 9, 0, 0, 1'b0, -1);
        check("abort_single_reread", n_reads, reads_before + 1);
        check("abort_no_done", n_done, done_before + 1);

        // Random back-to-back pairs with random configuration.
        for (int t = 0; t < 4; t++) begin
            r1 = int'($urandom_range(0, 511));
            r2 = int'($urandom_range(0, 511));
            push(r1); push(r2);
            run_frame(r1, int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 3)), 1'b0, -1);
            run_frame(r2, int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 3)), 1'b0, 2 * GAP_BITS);
        end

`ifdef UART_TX_TMR_EN
        // One corrupted state copy in INTERVAL is outvoted and scrubbed on the next clk.
        Enable_i = 1'b0;
        @(negedge clk);
        dut.core_r[1].state = 6'b00_0100;
        #1;
        check("tmr_state", State_o, 6'b00_0001);
        check("tmr_tx", Tx_o, 1);
        check("tmr_busy", Busy_o, 0);
        @(negedge clk);
        check("tmr_scrub", dut.core_r[1].state, 6'b00_0001);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
Parametrised UART transmit engine and the successor to the fixed 8-bit tx state machine. It pops bytes from the tx FIFO, serialises them onto Tx_o and supports runtime-selectable data length, parity mode, stop length and a minimum inter-frame gap. It sits between the tx FIFO and the pad. Timing comes from a half-bit tick supplied by the baudrate module.

Parameters:
DATA_MAX, 9, widest supported data field in bits (legal range 5..9)
GAP_BITS, 0, minimum idle bit-times forced between consecutive frames (0..15)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
p_HalfBaudSig_i  in  1  one-clk pulse at 2x baud rate; one bit = 2 ticks
p_FiFoEmpty_i  in  1  tx FIFO empty flag
FiFoData_i  in  DATA_MAX  FIFO read data, valid the clk after p_FiFoRead_o
p_FiFoRead_o  out  1  one-clk FIFO pop
Enable_i  in  1  transmitter enable
DataBits_i  in  4  data length, 5..DATA_MAX
ParityMode_i  in  3  000 none, 001 odd, 010 even, 011 mark, 100 space, others none
StopBits_i  in  2  00 one, 01 one-and-half, 10/11 two
Tx_o  out  1  serial line, idle high
State_o  out  6  one-hot state
BitCounter_o  out  4  data bits sent in the current frame
Busy_o  out  1  high in any state except INTERVAL
p_ByteDone_o  out  1  one-clk pulse at end of stop field

Behaviour:
- Reset values: State_o = INTERVAL (6'b00_0001), Tx_o = 1, all counters 0, p_FiFoRead_o = 0, p_ByteDone_o = 0, Busy_o = 0.
- States, one-hot: INTERVAL, LOAD, STARTBIT, DATABITS, PARITYBIT, STOPBIT.
- INTERVAL -> LOAD when all of these hold in the same clk:
  - !p_FiFoEmpty_i
  - Enable_i
  - p_HalfBaudSig_i
  - gap counter >= 2*GAP_BITS ticks
  p_FiFoRead_o is asserted in that same clk.
- LOAD lasts exactly 1 clk:
  - captures FiFoData_i into the shift register
  - latches DataBits_i, ParityMode_i and StopBits_i; changes to these later in the frame are ignored
  - clears the tick counter
  - goes to STARTBIT
- DataBits_i clamping at latch: values < 5 are used as 5; values > DATA_MAX are used as DATA_MAX.
- Tick counting: every state except INTERVAL counts p_HalfBaudSig_i pulses. A bit ends on its 2nd tick. State exit happens on the tick that ends the field.
- STARTBIT: Tx_o = 0 for 2 ticks, then DATABITS.
- DATABITS:
  - Tx_o = shift-register LSB, sent LSB first.
  - At each bit end: shift right, BitCounter_o increments, parity accumulator XORs in the bit.
  - When BitCounter_o reaches the latched length: go to PARITYBIT if parity is enabled, otherwise STOPBIT.
- PARITYBIT, 2 ticks. Tx_o by mode:
  - odd: ~XOR of the data bits
  - even: XOR of the data bits
  - mark: 1
  - space: 0
- STOPBIT: Tx_o = 1 for 2, 3 or 4 ticks (one, one-and-half, two). On the final tick:
  - pulse p_ByteDone_o
  - go to INTERVAL
  - clear the gap counter
- Gap counter: counts ticks in INTERVAL and saturates at 2*GAP_BITS.
- BitCounter_o is 0 outside DATABITS/PARITYBIT/STOPBIT. It holds its final value through PARITYBIT and STOPBIT.
- Tx_o is a registered output with no combinational glitching. It is 1 in INTERVAL and LOAD.
- Enable_i deasserted mid-frame: the current frame completes normally; no new frame starts.
- FIFO empty after a pop: no effect on the current frame.
- Back-to-back frames with GAP_BITS = 0: the next frame may start on the first tick after STOPBIT exits.
- rst asserted mid-frame: immediate return to the reset values. The partial frame is discarded and the FIFO is not re-read.
- Any illegal (non-one-hot) state: next clk goes to INTERVAL with Tx_o = 1 and counters cleared.

Optional Feature:
Macro UART_TX_TMR_EN.
- Defined: state, tick, bit and gap counters and the shift register are each triplicated. Every use, and every output, goes through a bitwise 2-of-3 majority vote, and all three copies are written from the voted next value. A single corrupted copy is masked and scrubbed on the next clk.
- Undefined: single registers, identical cycle behaviour, no voting logic.

Test Plan:
- 8N1 (DataBits=8, Parity=000, Stop=00), FIFO holds 0x55 -> Tx_o sequence 0,1,0,1,0,1,0,1,0,1, 2 ticks each; p_ByteDone_o pulses once, 20 ticks after LOAD.
- 7E2, data 0x41 -> start 0; data 1,0,0,0,0,0,1; parity 0; stop high for 4 ticks; BitCounter_o = 7 during stop.
- 5O1.5, data 0x1F -> five 1s, parity bit 0, stop high for 3 ticks.
- 9-bit mark parity (DATA_MAX=9), data 0x100 -> eight 0s, then 1, then parity 1. DataBits=3 behaves as 5 bits.
- GAP_BITS=2, two queued bytes -> Tx_o high for at least 4 ticks between frames.
- Reset mid-DATABITS -> Tx_o = 1 and State_o = INTERVAL with no clk edge. Enable_i=0 with a non-empty FIFO -> no p_FiFoRead_o.
- With UART_TX_TMR_EN, force one state copy to 6'b00_0100 while in INTERVAL -> outputs unchanged and the copy is restored next clk.
